// File: rtl/stratix_ddio_pkg.sv
// Shared types and constants for the DDR write-burst DDIO output controller.
package stratix_ddio_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_BURST = 3'd2,
    ST_POST  = 3'd3,
    ST_EXT   = 3'd4
  } state_e;

  // DQS DDIO datain pair, packed as {dqs_h, dqs_l}.
  localparam logic [1:0] DQS_IDLE  = 2'b00;
  localparam logic [1:0] DQS_PRE   = 2'b00;
  localparam logic [1:0] DQS_BURST = 2'b10;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/stratix_ddio_burst_fsm.sv
// Burst sequencer: state, beat/preamble/postamble counting, ready and output strobes.
module stratix_ddio_burst_fsm
  import stratix_ddio_pkg::*;
#(
  parameter int BURST_LEN   = 4,
  parameter int PRE_CYCLES  = 1,
  parameter int POST_CYCLES = 1,
  parameter bit EXT_EN      = 1'b0
) (
  input  logic   clk_i,
  input  logic   areset_i,
  input  logic   in_valid_i,
  output logic   in_ready_o,
  output logic   load_o,
  output logic   burst_o,
  output logic   pre_o,
  output logic   post_o,
  output logic   post_first_o,
  output logic   ext_o,
  output logic   tail_o,
  output state_e state_o
);

  localparam int CW = clog2(max3(BURST_LEN, PRE_CYCLES, POST_CYCLES) + 1);
  localparam logic [CW-1:0] BURST_LAST = CW'(BURST_LEN - 1);
  localparam logic [CW-1:0] PRE_LAST   = CW'((PRE_CYCLES > 0) ? PRE_CYCLES - 1 : 0);
  localparam logic [CW-1:0] POST_LAST  = CW'((POST_CYCLES > 0) ? POST_CYCLES - 1 : 0);
  localparam state_e START_ST = (PRE_CYCLES > 0) ? ST_PRE : ST_BURST;
  localparam state_e TAIL_ST  = (POST_CYCLES > 0) ? ST_POST : (EXT_EN ? ST_EXT : ST_IDLE);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_eff;
  logic          tail_q, tail_d;
  logic          merge, in_burst;

  // tail_q marks the cycle right after a last beat; a valid beat there
  // continues the stream as beat 0 of the next burst with no gap.
  assign merge    = tail_q && in_valid_i;
  assign in_burst = (state_q == ST_BURST) || merge;
  assign cnt_eff  = merge ? '0 : cnt_q;

  always_ff @(posedge clk_i) begin
    if (areset_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      tail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tail_q  <= tail_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tail_d  = 1'b0;
    if (in_burst) begin
      if (cnt_eff == BURST_LAST) begin
        state_d = TAIL_ST;
        cnt_d   = '0;
        tail_d  = 1'b1;
      end else begin
        state_d = ST_BURST;
        cnt_d   = cnt_eff + 1'b1;
      end
    end else begin
      case (state_q)
        ST_IDLE, ST_EXT: begin
          state_d = in_valid_i ? START_ST : ST_IDLE;
          cnt_d   = '0;
        end
        ST_PRE: begin
          if (cnt_q == PRE_LAST) begin
            state_d = ST_BURST;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_POST: begin
          if (in_valid_i) begin
            state_d = START_ST;
            cnt_d   = '0;
          end else if (cnt_q == POST_LAST) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign in_ready_o   = in_burst;
  assign load_o       = in_burst && in_valid_i;
  assign burst_o      = in_burst;
  assign pre_o        = !in_burst && (state_q == ST_PRE);
  assign post_o       = !in_burst && (state_q == ST_POST);
  assign post_first_o = post_o && tail_q;
  assign ext_o        = !in_burst && (state_q == ST_EXT);
  assign tail_o       = tail_q;
  assign state_o      = state_q;

endmodule

// File: rtl/stratix_ddio_bidir_burst_out.sv
// DDR write-burst driver for one DQ/DQS strobe group of DDIO bidir output cells.
// Handshake: a beat transfers on a rising clk edge where in_valid && in_ready.
module stratix_ddio_bidir_burst_out
  import stratix_ddio_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               BURST_LEN   = 4,
  parameter int               PRE_CYCLES  = 1,
  parameter int               POST_CYCLES = 1,
  parameter string            EXTEND_OE   = "false",
  parameter logic [WIDTH-1:0] IDLE_VALUE  = '0
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data_h,
  input  logic [WIDTH-1:0] in_data_l,
  output logic [WIDTH-1:0] dq_h,
  output logic [WIDTH-1:0] dq_l,
  output logic             dq_oe,
  output logic             dqs_h,
  output logic             dqs_l,
  output logic             dqs_oe,
  output logic             busy,
  output logic             underrun
);

  localparam bit EXT_EN = (EXTEND_OE == "true");

  logic   load, burst, pre, post, post_first, ext, tail;
  state_e fsm_state;

  stratix_ddio_burst_fsm #(
    .BURST_LEN  (BURST_LEN),
    .PRE_CYCLES (PRE_CYCLES),
    .POST_CYCLES(POST_CYCLES),
    .EXT_EN     (EXT_EN)
  ) u_fsm (
    .clk_i       (clk),
    .areset_i    (areset),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .load_o      (load),
    .burst_o     (burst),
    .pre_o       (pre),
    .post_o      (post),
    .post_first_o(post_first),
    .ext_o       (ext),
    .tail_o      (tail),
    .state_o     (fsm_state)
  );

  logic [WIDTH-1:0] dq_h_q, dq_h_d, dq_l_q, dq_l_d;
  logic             dq_oe_q, dq_oe_d, dqs_oe_q, dqs_oe_d, underrun_q, underrun_d;
  logic [1:0]       dqs_q, dqs_d;

  always_comb begin
    dq_h_d     = load ? in_data_h : IDLE_VALUE;
    dq_l_d     = load ? in_data_l : IDLE_VALUE;
    dq_oe_d    = burst || ext || (post_first && EXT_EN);
    dqs_oe_d   = burst || pre || post;
    dqs_d      = burst ? DQS_BURST : ((pre || post) ? DQS_PRE : DQS_IDLE);
    // An empty beat slot still drives DQ, so the lapse is only recorded.
    underrun_d = underrun_q || (burst && !in_valid);
  end

  always_ff @(posedge clk) begin
    if (areset) begin
      dq_h_q     <= IDLE_VALUE;
      dq_l_q     <= IDLE_VALUE;
      dq_oe_q    <= 1'b0;
      dqs_oe_q   <= 1'b0;
      dqs_q      <= DQS_IDLE;
      underrun_q <= 1'b0;
    end else begin
      dq_h_q     <= dq_h_d;
      dq_l_q     <= dq_l_d;
      dq_oe_q    <= dq_oe_d;
      dqs_oe_q   <= dqs_oe_d;
      dqs_q      <= dqs_d;
      underrun_q <= underrun_d;
    end
  end

  assign dq_h           = dq_h_q;
  assign dq_l           = dq_l_q;
  assign dq_oe          = dq_oe_q;
  assign dqs_oe         = dqs_oe_q;
  assign {dqs_h, dqs_l} = dqs_q;
  assign underrun       = underrun_q;
  // The cycle after a last beat still counts as busy while a merge is possible.
  assign busy           = (fsm_state != ST_IDLE) || tail;

endmodule

// File: doc/stratix_ddio_bidir_burst_out.md
Name: stratix_ddio_bidir_burst_out

Overview:
- Parametrised DDR bidirectional write-burst controller. Feeds WIDTH-bit data-strobe group DDIO output atoms, one per DQ bit plus one for DQS.
- Accepts beats over a valid/ready stream and emits registered high/low data, DQ output-enable and DQS waveform with configurable preamble/postamble.
- Merges back-to-back bursts seamlessly and flags stream underrun.
- Sits between the memory-controller write datapath and the per-pin DDIO bidir output cells.

Parameters:
- WIDTH, 8, DQ bits per strobe group (1..36)
- BURST_LEN, 4, beats per burst; one beat = one clk cycle = two DDR edges (2..16)
- PRE_CYCLES, 1, DQS preamble cycles before the first beat (0..3)
- POST_CYCLES, 1, DQS postamble cycles after the last beat (0..3)
- EXTEND_OE, "false", "true" holds dq_oe one extra cycle after the final beat
- IDLE_VALUE, 0, WIDTH-bit value driven on dq_h/dq_l when no valid beat is present

Ports:
- clk  in  1  single clock; all logic on rising edge
- areset  in  1  synchronous active-high reset, sampled on rising clk
- in_valid  in  1  beat available
- in_ready  out  1  beat accepted when in_valid && in_ready
- in_data_h  in  WIDTH  data for rising edge
- in_data_l  in  WIDTH  data for falling edge
- dq_h  out  WIDTH  to DDIO datain_h, per bit
- dq_l  out  WIDTH  to DDIO datain_l, per bit
- dq_oe  out  1  DQ output enable
- dqs_h  out  1  DQS DDIO datain_h
- dqs_l  out  1  DQS DDIO datain_l
- dqs_oe  out  1  DQS output enable
- busy  out  1  state != IDLE
- underrun  out  1  sticky: in_valid low during a BURST cycle

Behaviour:
- Reset (areset high at an edge):
  - state = IDLE.
  - dq_h = dq_l = IDLE_VALUE.
  - dq_oe, dqs_oe, dqs_h, dqs_l, busy, underrun, in_ready = 0.
  - Beat counter = 0.
  - Reset mid-burst aborts immediately; the partial burst is not resumed.
- States: IDLE, PRE, BURST, POST, EXT.
- IDLE:
  - in_valid=1 -> PRE if PRE_CYCLES>0, else BURST.
  - No beat is consumed in IDLE.
- PRE:
  - Lasts PRE_CYCLES cycles, then -> BURST.
  - Registered outputs: dqs_oe=1, dqs_h=0, dqs_l=0, dq_oe=0.
- BURST:
  - Exactly BURST_LEN cycles; beat counter 0..BURST_LEN-1.
  - in_ready=1, combinational from state.
  - Accepted beat: dq_h/dq_l <= in_data_h/in_data_l on the next edge, giving 1-cycle latency; dq_oe=1, dqs_oe=1, dqs_h=1, dqs_l=0.
  - in_valid=0 in a BURST cycle (underrun): beat slot still consumed, counter advances, dq_h/dq_l <= IDLE_VALUE, dq_oe stays 1, underrun <= 1.
  - underrun clears only on reset.
- Last beat (counter = BURST_LEN-1):
  - in_valid=1 on the cycle after the last beat: next burst starts directly in BURST, counter wraps to 0, no postamble/preamble. DQS/DQ enables remain continuous.
  - Otherwise -> POST if POST_CYCLES>0, else EXT if EXTEND_OE="true", else IDLE.
- POST:
  - Lasts POST_CYCLES cycles.
  - dqs_oe=1, dqs_h=0, dqs_l=0.
  - dq_oe=1 only in the first POST cycle when EXTEND_OE="true", else 0.
  - in_valid=1 during POST -> PRE, since a new preamble is required. POST ends early.
  - Then -> IDLE.
- EXT (only when POST_CYCLES=0 and EXTEND_OE="true"):
  - One cycle: dq_oe=1, dqs_oe=0, dq_h/dq_l = IDLE_VALUE.
  - Then -> IDLE, or -> PRE/BURST on in_valid, same as IDLE.
- All outputs except in_ready are registered.
- Counters are sized clog2(max(BURST_LEN, PRE_CYCLES, POST_CYCLES)+1).

Decomposition:
- Shared package (stratix_ddio_pkg):
  - state enum;
  - DQS_IDLE/DQS_PRE/DQS_BURST encoding constants;
  - clog2 function.
- One natural sub-module, stratix_ddio_burst_fsm:
  - owns state, beat counter, preamble/postamble counters;
  - produces in_ready and the load/enable strobes.
- Top level holds the WIDTH-wide data registers and the registered DQS/OE outputs.

Test Plan:
- Reset values: areset=1 for 2 cycles with in_valid=1 -> all outputs 0/IDLE_VALUE, busy=0, in_ready=0.
- Single burst, WIDTH=8, BURST_LEN=4, PRE=1, POST=1, beats h=0x11,0x22,0x33,0x44 / l=0xA1..0xA4:
  - cycle 1: dqs_oe=1 with dqs 0/0;
  - cycles 2-5: dq_oe=1, dqs_h=1, data in order;
  - cycle 6: postamble dqs_oe=1, dq_oe=0;
  - cycle 7: all enables 0.
- Back-to-back: two 4-beat bursts with in_valid held high -> 8 consecutive BURST cycles, dq_oe/dqs_oe never drop, no PRE/POST between bursts.
- Underrun: drop in_valid on beat 2 -> dq_h=dq_l=IDLE_VALUE for that beat, underrun=1 and stays 1, burst still ends after 4 beats.
- EXTEND_OE="true", POST_CYCLES=0 -> dq_oe high exactly one cycle after the last beat with dqs_oe=0, then IDLE.
- Reset mid-burst after beat 1 -> next cycle state IDLE, all enables 0. A fresh burst then starts with a full preamble and counter from 0.
